// File: rtl/poly_mul_tile_scheduler_if.sv
// Handshake bundle between the tensor-product requester, the tile scheduler and the
// polynomial multiplier. Signal names keep their direction suffix as seen from the scheduler.
interface poly_mul_tile_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             mul_ready_i;
  logic             mul_done_i;
  logic             start_o;
  logic             a_sel_o;
  logic             b_sel_o;
  logic [IDX_W-1:0] a_tile_o;
  logic [IDX_W-1:0] b_tile_o;
  logic [1:0]       prod_idx_o;
  logic             clr_mul_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  // scheduler side
  modport master (
    input  cmd_valid_i, mul_ready_i, mul_done_i,
    output cmd_ready_o, start_o, a_sel_o, b_sel_o, a_tile_o, b_tile_o,
           prod_idx_o, clr_mul_o, busy_o, done_o, err_o
  );

  // requester / multiplier side
  modport slave (
    output cmd_valid_i, mul_ready_i, mul_done_i,
    input  cmd_ready_o, start_o, a_sel_o, b_sel_o, a_tile_o, b_tile_o,
           prod_idx_o, clr_mul_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/poly_mul_tile_scheduler.sv
// Sequences the four ciphertext-component products of one tensor product, issuing every
// (i, j) tile pair row-major to the multiplier. Optional watchdog: SCHED_TIMEOUT_EN.
`ifndef DEGREE_N
`define DEGREE_N 1024
`endif
`ifndef TILE_N
`define TILE_N 256
`endif

module poly_mul_tile_scheduler #(
  parameter int TILE_COUNT     = `DEGREE_N / `TILE_N,
  parameter int IDX_W          = $clog2(TILE_COUNT),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                       clk,
  input logic                       rst,
  poly_mul_tile_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_RDY  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CLEAR     = 3'd4;
`ifdef SCHED_TIMEOUT_EN
  localparam logic [2:0] S_ERR       = 3'd5;
  localparam int         CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
`endif

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TILE_COUNT - 1);

  logic [2:0]       state, state_nxt;
  logic [1:0]       prod;
  logic [IDX_W-1:0] ti, tj;
  logic             last_tile;
  logic             in_err;

  assign last_tile = (ti == LAST) && (tj == LAST);

`ifdef SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_hit;
  logic             in_wait;

  assign in_wait = (state == S_WAIT_RDY) || (state == S_WAIT_DONE);
  assign wd_hit  = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_err  = (state == S_ERR);

  // Counts cycles spent parked in one wait state; any exit (including to ERR) restarts it.
  always_ff @(posedge clk) begin
    if (rst)                             wd_cnt <= '0;
    else if (in_wait && state_nxt == state) wd_cnt <= wd_cnt + 1'b1;
    else                                 wd_cnt <= '0;
  end
`else
  assign in_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.cmd_valid_i) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = last_tile ? S_WAIT_DONE : S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (bus.mul_ready_i) state_nxt = S_ISSUE;
`ifdef SCHED_TIMEOUT_EN
        else if (wd_hit)     state_nxt = S_ERR;
`endif
      end
      S_WAIT_DONE: begin
        if (bus.mul_done_i)  state_nxt = S_CLEAR;
`ifdef SCHED_TIMEOUT_EN
        else if (wd_hit)     state_nxt = S_ERR;
`endif
      end
      // the first tile of the next product goes out without waiting on ready
      S_CLEAR:     state_nxt = (prod == 2'd3) ? S_IDLE : S_ISSUE;
`ifdef SCHED_TIMEOUT_EN
      S_ERR:       state_nxt = S_ERR;
`endif
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      prod  <= 2'd0;
      ti    <= '0;
      tj    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (bus.cmd_valid_i) begin
          prod <= 2'd0;
          ti   <= '0;
          tj   <= '0;
        end
        S_ISSUE: if (!last_tile) begin
          if (tj == LAST) begin
            tj <= '0;
            ti <= ti + 1'b1;
          end else begin
            tj <= tj + 1'b1;
          end
        end
        S_CLEAR: if (prod != 2'd3) begin
          prod <= prod + 2'd1;
          ti   <= '0;
          tj   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Pulses and status are masked by rst so a mid-command reset never leaks a done pulse.
  assign bus.cmd_ready_o = !rst && (state == S_IDLE);
  assign bus.busy_o      = !rst && (state != S_IDLE);
  assign bus.start_o     = !rst && (state == S_ISSUE);
  assign bus.clr_mul_o   = !rst && ((state == S_CLEAR) || in_err);
  assign bus.done_o      = !rst && (state == S_CLEAR) && (prod == 2'd3);
  assign bus.err_o       = !rst && in_err;
  assign bus.a_tile_o    = ti;
  assign bus.b_tile_o    = tj;
  assign bus.prod_idx_o  = prod;
  // product order (1,1) (0,1) (1,0) (0,0)
  assign bus.a_sel_o     = ~prod[0];
  assign bus.b_sel_o     = ~prod[1];

endmodule

// File: tb/tb_poly_mul_tile_scheduler.sv
// Directed bench for poly_mul_tile_scheduler with TILE_COUNT=4 and a 16-cycle watchdog limit.
module tb_poly_mul_tile_scheduler;
  localparam int TC = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  poly_mul_tile_scheduler_if #(.IDX_W(IW)) bus ();

  poly_mul_tile_scheduler #(.TILE_COUNT(TC), .IDX_W(IW), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One command; mul_done is pulsed 3 cycles after each 16th start. Optional: hold cmd_valid,
  // spurious done in WAIT_RDY, ready low for 10 cycles after the first start, reset at start abort_k.
  task automatic run_cmd(input bit hold, input bit spur, input bit rdy_low, input int abort_k);
    int k = 0, clr_n = 0, done_n = 0, t0 = 0;
    int done_at = -1, last_done = -100, rdy_back = -1, spur_at = -1;
    logic [1:0] sel_tab [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic [7:0] e;
    bus.cmd_valid_i = 1'b1;
    step();
    if (!hold) bus.cmd_valid_i = 1'b0;
    for (int n = 0; n < 600 && done_n == 0; n++) begin
      bus.mul_done_i = (cyc == done_at) || (cyc == spur_at);
      if (cyc == done_at) last_done = cyc;
      if (cyc == rdy_back) bus.mul_ready_i = 1'b1;
      if (bus.start_o) begin
        if (k < 64) begin
          e = {2'(k / 16), sel_tab[k / 16], 2'((k % 16) / 4), 2'(k % 4)};
          check("start_fields", {bus.prod_idx_o, bus.a_sel_o, bus.b_sel_o,
                                 bus.a_tile_o, bus.b_tile_o}, e);
        end else begin
          check("extra_start", k, 63);
        end
        if (k == 0) begin
          t0 = cyc;
          if (spur) spur_at = t0 + 1;
          if (rdy_low) begin
            bus.mul_ready_i = 1'b0;
            rdy_back = t0 + 11;
          end
        end
        if (k == 1) check("issue_gap", cyc - t0, rdy_low ? 12 : 2);
        if (k % 16 == 15) done_at = cyc + 3;
        if (k == abort_k) begin
          rst = 1'b1;
          step();
          check("rst_outputs", {bus.start_o, bus.clr_mul_o, bus.done_o, bus.err_o,
                                bus.busy_o, bus.cmd_ready_o}, 0);
          rst = 1'b0;
          bus.mul_done_i = 1'b0;
          step();
          check("after_rst_idle", {bus.cmd_ready_o, bus.busy_o, bus.done_o}, 3'b100);
          return;
        end
        k++;
      end
      if (bus.clr_mul_o) begin
        clr_n++;
        check("clr_after_done", cyc - last_done, 1);
      end
      if (bus.done_o) begin
        done_n++;
        check("done_with_clr4", clr_n, 4);
        bus.cmd_valid_i = 1'b0;
      end
      step();
    end
    bus.mul_done_i = 1'b0;
    check("start_count", k, 64);
    check("clr_count", clr_n, 4);
    check("done_count", done_n, 1);
    check("idle_after", {bus.cmd_ready_o, bus.busy_o}, 2'b10);
    step();
    check("no_reaccept", {bus.start_o, bus.busy_o}, 2'b00);
  endtask

  initial begin
    int k, s;
    bus.cmd_valid_i = 1'b0;
    bus.mul_ready_i = 1'b1;
    bus.mul_done_i  = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("reset_outputs", {bus.cmd_ready_o, bus.busy_o, bus.start_o, bus.clr_mul_o,
                            bus.done_o, bus.err_o}, 0);
    rst = 1'b0;
    step();
    check("post_reset_idle", {bus.cmd_ready_o, bus.busy_o, bus.prod_idx_o}, 4'b1000);

    run_cmd(1'b0, 1'b0, 1'b0, -1);
    run_cmd(1'b0, 1'b0, 1'b1, -1);
    run_cmd(1'b1, 1'b1, 1'b0, -1);
    run_cmd(1'b0, 1'b0, 1'b0, 39);
    run_cmd(1'b0, 1'b0, 1'b0, -1);

    // Watchdog: never complete the first product.
    bus.cmd_valid_i = 1'b1;
    step();
    bus.cmd_valid_i = 1'b0;
    k = 0;
    s = 0;
    for (int n = 0; n < 200 && k < 16; n++) begin
      if (bus.start_o) begin
        k++;
        s = cyc;
      end
      if (k < 16) step();
    end
    check("wd_starts", k, 16);
    repeat (16) step();
    check("wd_before_limit", {bus.err_o, bus.clr_mul_o, bus.busy_o}, 3'b001);
    step();
    check("wd_elapsed", cyc - s, 17);
`ifdef SCHED_TIMEOUT_EN
    check("wd_err_set", {bus.err_o, bus.clr_mul_o, bus.cmd_ready_o}, 3'b110);
    repeat (5) step();
    check("wd_err_held", {bus.err_o, bus.clr_mul_o, bus.cmd_ready_o, bus.busy_o}, 4'b1101);
`else
    check("wd_off_waits", {bus.err_o, bus.clr_mul_o, bus.busy_o}, 3'b001);
    repeat (30) step();
    check("wd_off_still", {bus.err_o, bus.start_o, bus.busy_o, bus.cmd_ready_o}, 4'b0010);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("final_idle", {bus.cmd_ready_o, bus.busy_o, bus.err_o, bus.clr_mul_o}, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
